// File: rtl/multi_core_pkg.sv
// Shared constants and fixed coefficient functions for the multi_core neuron array.
package multi_core_pkg;

  localparam int NCORES = 51;
  localparam int NIN    = 8;
  localparam int IN_W   = 19;
  localparam int OUT_W  = 28;
  localparam int WGT_W  = 5;
  localparam int IDX_W  = 3;

  // Sequencer phase: consume a sample, then spend one cycle waiting for the source.
  typedef enum logic {
    PH_CONSUME = 1'b0,
    PH_WAIT    = 1'b1
  } phase_t;

  // Fixed weight of core k for sample i, range -7..7.
  function automatic logic signed [WGT_W-1:0] wgt(input int k, input int i);
    int v;
    v = ((7 * k + 3 * i) % 15) - 7;
    return WGT_W'(v);
  endfunction

  // Fixed bias of core k.
  function automatic logic signed [OUT_W-1:0] bias(input int k);
    return OUT_W'(k);
  endfunction

endpackage

// File: rtl/multi_core_mac.sv
// One fixed-weight neuron: accumulates in*W[CORE_ID][idx] per consumed sample and
// publishes acc+bias on the emit strobe, clearing the accumulator for the next frame.
module mac_core
  import multi_core_pkg::*;
#(
  parameter int CORE_ID = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             consume,
  input  logic [IDX_W-1:0] idx,
  input  logic             emit,
  output logic [OUT_W-1:0] result,
  output logic             valid
);

  localparam logic signed [OUT_W-1:0] BIAS = bias(CORE_ID);

  logic signed [WGT_W-1:0] w;
  logic signed [OUT_W-1:0] in_x;
  logic signed [OUT_W-1:0] w_x;
  logic signed [OUT_W-1:0] prod;
  logic signed [OUT_W-1:0] acc;

  // Weight lookup for the current sample index (constant-folds to a tiny table).
  always_comb begin
    w = wgt(CORE_ID, int'(idx));
  end

  // Sign-extend both operands; the product always fits in OUT_W bits.
  assign in_x = {{(OUT_W - IN_W){in[IN_W-1]}}, in};
  assign w_x  = {{(OUT_W - WGT_W){w[WGT_W-1]}}, w};
  assign prod = in_x * w_x;

  // Accumulate on consuming edges; on emit publish the frame result and restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= emit;
      if (emit) begin
        result <= acc + BIAS;
        acc    <= '0;
      end else if (consume) begin
        acc <= acc + prod;
      end
    end
  end

endmodule

// File: rtl/multi_core.sv
// Array of NCORES fixed-weight neuron cores fed by one broadcast sample stream.
// Handshake: req_inK=1 for the cycle after a consuming edge tells the source that
// `in` was taken and the next sample must be stable by the following edge;
// out_enK=1 marks the single cycle in which io_outK carries a fresh frame result,
// which then holds until the next frame. There is no back-pressure on either side.
module multi_core
  import multi_core_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] io_out0, io_out1, io_out2, io_out3, io_out4, io_out5, io_out6, io_out7, io_out8, io_out9,
                           io_out10, io_out11, io_out12, io_out13, io_out14, io_out15, io_out16, io_out17, io_out18, io_out19,
                           io_out20, io_out21, io_out22, io_out23, io_out24, io_out25, io_out26, io_out27, io_out28, io_out29,
                           io_out30, io_out31, io_out32, io_out33, io_out34, io_out35, io_out36, io_out37, io_out38, io_out39,
                           io_out40, io_out41, io_out42, io_out43, io_out44, io_out45, io_out46, io_out47, io_out48, io_out49,
                           io_out50,
  output logic [3:0]       req_in0, req_in1, req_in2, req_in3, req_in4, req_in5, req_in6, req_in7, req_in8, req_in9,
                           req_in10, req_in11, req_in12, req_in13, req_in14, req_in15, req_in16, req_in17, req_in18, req_in19,
                           req_in20, req_in21, req_in22, req_in23, req_in24, req_in25, req_in26, req_in27, req_in28, req_in29,
                           req_in30, req_in31, req_in32, req_in33, req_in34, req_in35, req_in36, req_in37, req_in38, req_in39,
                           req_in40, req_in41, req_in42, req_in43, req_in44, req_in45, req_in46, req_in47, req_in48, req_in49,
                           req_in50,
  output logic [3:0]       out_en0, out_en1, out_en2, out_en3, out_en4, out_en5, out_en6, out_en7, out_en8, out_en9,
                           out_en10, out_en11, out_en12, out_en13, out_en14, out_en15, out_en16, out_en17, out_en18, out_en19,
                           out_en20, out_en21, out_en22, out_en23, out_en24, out_en25, out_en26, out_en27, out_en28, out_en29,
                           out_en30, out_en31, out_en32, out_en33, out_en34, out_en35, out_en36, out_en37, out_en38, out_en39,
                           out_en40, out_en41, out_en42, out_en43, out_en44, out_en45, out_en46, out_en47, out_en48, out_en49,
                           out_en50
);

  phase_t           phase;
  logic [IDX_W-1:0] idx;
  logic [3:0]       req;
  logic             consume;
  logic             emit;
  logic [OUT_W-1:0] res [NCORES];
  logic [NCORES-1:0] vld;

  // Emit falls on the wait edge right after the last sample, when idx has wrapped.
  assign consume = (phase == PH_CONSUME);
  assign emit    = (phase == PH_WAIT) && (idx == '0);

  // Sequencer: alternate consume/wait, step the sample index, register the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_CONSUME;
      idx   <= '0;
      req   <= 4'd0;
    end else begin
      phase <= consume ? PH_WAIT : PH_CONSUME;
      req   <= consume ? 4'd1 : 4'd0;
      if (consume) idx <= idx + 1'b1;
    end
  end

  for (genvar k = 0; k < NCORES; k++) begin : g_core
    mac_core #(.CORE_ID(k)) u_core (
      .clk(clk), .rst(rst), .in(in), .consume(consume), .idx(idx), .emit(emit),
      .result(res[k]), .valid(vld[k])
    );
  end

  assign io_out0 = res[0];   assign io_out1 = res[1];   assign io_out2 = res[2];   assign io_out3 = res[3];   assign io_out4 = res[4];   assign io_out5 = res[5];
  assign io_out6 = res[6];   assign io_out7 = res[7];   assign io_out8 = res[8];   assign io_out9 = res[9];   assign io_out10 = res[10]; assign io_out11 = res[11];
  assign io_out12 = res[12]; assign io_out13 = res[13]; assign io_out14 = res[14]; assign io_out15 = res[15]; assign io_out16 = res[16]; assign io_out17 = res[17];
  assign io_out18 = res[18]; assign io_out19 = res[19]; assign io_out20 = res[20]; assign io_out21 = res[21]; assign io_out22 = res[22]; assign io_out23 = res[23];
  assign io_out24 = res[24]; assign io_out25 = res[25]; assign io_out26 = res[26]; assign io_out27 = res[27]; assign io_out28 = res[28]; assign io_out29 = res[29];
  assign io_out30 = res[30]; assign io_out31 = res[31]; assign io_out32 = res[32]; assign io_out33 = res[33]; assign io_out34 = res[34]; assign io_out35 = res[35];
  assign io_out36 = res[36]; assign io_out37 = res[37]; assign io_out38 = res[38]; assign io_out39 = res[39]; assign io_out40 = res[40]; assign io_out41 = res[41];
  assign io_out42 = res[42]; assign io_out43 = res[43]; assign io_out44 = res[44]; assign io_out45 = res[45]; assign io_out46 = res[46]; assign io_out47 = res[47];
  assign io_out48 = res[48]; assign io_out49 = res[49]; assign io_out50 = res[50];

  assign req_in0 = req;  assign req_in1 = req;  assign req_in2 = req;  assign req_in3 = req;  assign req_in4 = req;  assign req_in5 = req;  assign req_in6 = req;
  assign req_in7 = req;  assign req_in8 = req;  assign req_in9 = req;  assign req_in10 = req; assign req_in11 = req; assign req_in12 = req; assign req_in13 = req;
  assign req_in14 = req; assign req_in15 = req; assign req_in16 = req; assign req_in17 = req; assign req_in18 = req; assign req_in19 = req; assign req_in20 = req;
  assign req_in21 = req; assign req_in22 = req; assign req_in23 = req; assign req_in24 = req; assign req_in25 = req; assign req_in26 = req; assign req_in27 = req;
  assign req_in28 = req; assign req_in29 = req; assign req_in30 = req; assign req_in31 = req; assign req_in32 = req; assign req_in33 = req; assign req_in34 = req;
  assign req_in35 = req; assign req_in36 = req; assign req_in37 = req; assign req_in38 = req; assign req_in39 = req; assign req_in40 = req; assign req_in41 = req;
  assign req_in42 = req; assign req_in43 = req; assign req_in44 = req; assign req_in45 = req; assign req_in46 = req; assign req_in47 = req; assign req_in48 = req;
  assign req_in49 = req; assign req_in50 = req;

  assign out_en0 = {3'b000, vld[0]};   assign out_en1 = {3'b000, vld[1]};   assign out_en2 = {3'b000, vld[2]};   assign out_en3 = {3'b000, vld[3]};
  assign out_en4 = {3'b000, vld[4]};   assign out_en5 = {3'b000, vld[5]};   assign out_en6 = {3'b000, vld[6]};   assign out_en7 = {3'b000, vld[7]};
  assign out_en8 = {3'b000, vld[8]};   assign out_en9 = {3'b000, vld[9]};   assign out_en10 = {3'b000, vld[10]}; assign out_en11 = {3'b000, vld[11]};
  assign out_en12 = {3'b000, vld[12]}; assign out_en13 = {3'b000, vld[13]}; assign out_en14 = {3'b000, vld[14]}; assign out_en15 = {3'b000, vld[15]};
  assign out_en16 = {3'b000, vld[16]}; assign out_en17 = {3'b000, vld[17]}; assign out_en18 = {3'b000, vld[18]}; assign out_en19 = {3'b000, vld[19]};
  assign out_en20 = {3'b000, vld[20]}; assign out_en21 = {3'b000, vld[21]}; assign out_en22 = {3'b000, vld[22]}; assign out_en23 = {3'b000, vld[23]};
  assign out_en24 = {3'b000, vld[24]}; assign out_en25 = {3'b000, vld[25]}; assign out_en26 = {3'b000, vld[26]}; assign out_en27 = {3'b000, vld[27]};
  assign out_en28 = {3'b000, vld[28]}; assign out_en29 = {3'b000, vld[29]}; assign out_en30 = {3'b000, vld[30]}; assign out_en31 = {3'b000, vld[31]};
  assign out_en32 = {3'b000, vld[32]}; assign out_en33 = {3'b000, vld[33]}; assign out_en34 = {3'b000, vld[34]}; assign out_en35 = {3'b000, vld[35]};
  assign out_en36 = {3'b000, vld[36]}; assign out_en37 = {3'b000, vld[37]}; assign out_en38 = {3'b000, vld[38]}; assign out_en39 = {3'b000, vld[39]};
  assign out_en40 = {3'b000, vld[40]}; assign out_en41 = {3'b000, vld[41]}; assign out_en42 = {3'b000, vld[42]}; assign out_en43 = {3'b000, vld[43]};
  assign out_en44 = {3'b000, vld[44]}; assign out_en45 = {3'b000, vld[45]}; assign out_en46 = {3'b000, vld[46]}; assign out_en47 = {3'b000, vld[47]};
  assign out_en48 = {3'b000, vld[48]}; assign out_en49 = {3'b000, vld[49]}; assign out_en50 = {3'b000, vld[50]};

endmodule

// File: tb/tb_multi_core.sv
// Self-checking bench for multi_core: randomized and directed frames against a
// frame-level reference model, with cycle-accurate req/out_en and hold checks.
module tb_multi_core;

  localparam int NC = 51;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [18:0] in;
  always #5 clk = ~clk;

  logic [NC-1:0][27:0] io_out_v;
  logic [NC-1:0][3:0]  req_v;
  logic [NC-1:0][3:0]  en_v;

  multi_core dut (
    .clk(clk), .rst(rst), .in(in),
    .io_out0(io_out_v[0]), .io_out1(io_out_v[1]), .io_out2(io_out_v[2]), .io_out3(io_out_v[3]), .io_out4(io_out_v[4]), .io_out5(io_out_v[5]),
    .io_out6(io_out_v[6]), .io_out7(io_out_v[7]), .io_out8(io_out_v[8]), .io_out9(io_out_v[9]), .io_out10(io_out_v[10]), .io_out11(io_out_v[11]),
    .io_out12(io_out_v[12]), .io_out13(io_out_v[13]), .io_out14(io_out_v[14]), .io_out15(io_out_v[15]), .io_out16(io_out_v[16]), .io_out17(io_out_v[17]),
    .io_out18(io_out_v[18]), .io_out19(io_out_v[19]), .io_out20(io_out_v[20]), .io_out21(io_out_v[21]), .io_out22(io_out_v[22]), .io_out23(io_out_v[23]),
    .io_out24(io_out_v[24]), .io_out25(io_out_v[25]), .io_out26(io_out_v[26]), .io_out27(io_out_v[27]), .io_out28(io_out_v[28]), .io_out29(io_out_v[29]),
    .io_out30(io_out_v[30]), .io_out31(io_out_v[31]), .io_out32(io_out_v[32]), .io_out33(io_out_v[33]), .io_out34(io_out_v[34]), .io_out35(io_out_v[35]),
    .io_out36(io_out_v[36]), .io_out37(io_out_v[37]), .io_out38(io_out_v[38]), .io_out39(io_out_v[39]), .io_out40(io_out_v[40]), .io_out41(io_out_v[41]),
    .io_out42(io_out_v[42]), .io_out43(io_out_v[43]), .io_out44(io_out_v[44]), .io_out45(io_out_v[45]), .io_out46(io_out_v[46]), .io_out47(io_out_v[47]),
    .io_out48(io_out_v[48]), .io_out49(io_out_v[49]), .io_out50(io_out_v[50]),
    .req_in0(req_v[0]), .req_in1(req_v[1]), .req_in2(req_v[2]), .req_in3(req_v[3]), .req_in4(req_v[4]), .req_in5(req_v[5]), .req_in6(req_v[6]),
    .req_in7(req_v[7]), .req_in8(req_v[8]), .req_in9(req_v[9]), .req_in10(req_v[10]), .req_in11(req_v[11]), .req_in12(req_v[12]), .req_in13(req_v[13]),
    .req_in14(req_v[14]), .req_in15(req_v[15]), .req_in16(req_v[16]), .req_in17(req_v[17]), .req_in18(req_v[18]), .req_in19(req_v[19]), .req_in20(req_v[20]),
    .req_in21(req_v[21]), .req_in22(req_v[22]), .req_in23(req_v[23]), .req_in24(req_v[24]), .req_in25(req_v[25]), .req_in26(req_v[26]), .req_in27(req_v[27]),
    .req_in28(req_v[28]), .req_in29(req_v[29]), .req_in30(req_v[30]), .req_in31(req_v[31]), .req_in32(req_v[32]), .req_in33(req_v[33]), .req_in34(req_v[34]),
    .req_in35(req_v[35]), .req_in36(req_v[36]), .req_in37(req_v[37]), .req_in38(req_v[38]), .req_in39(req_v[39]), .req_in40(req_v[40]), .req_in41(req_v[41]),
    .req_in42(req_v[42]), .req_in43(req_v[43]), .req_in44(req_v[44]), .req_in45(req_v[45]), .req_in46(req_v[46]), .req_in47(req_v[47]), .req_in48(req_v[48]),
    .req_in49(req_v[49]), .req_in50(req_v[50]),
    .out_en0(en_v[0]), .out_en1(en_v[1]), .out_en2(en_v[2]), .out_en3(en_v[3]), .out_en4(en_v[4]), .out_en5(en_v[5]), .out_en6(en_v[6]),
    .out_en7(en_v[7]), .out_en8(en_v[8]), .out_en9(en_v[9]), .out_en10(en_v[10]), .out_en11(en_v[11]), .out_en12(en_v[12]), .out_en13(en_v[13]),
    .out_en14(en_v[14]), .out_en15(en_v[15]), .out_en16(en_v[16]), .out_en17(en_v[17]), .out_en18(en_v[18]), .out_en19(en_v[19]), .out_en20(en_v[20]),
    .out_en21(en_v[21]), .out_en22(en_v[22]), .out_en23(en_v[23]), .out_en24(en_v[24]), .out_en25(en_v[25]), .out_en26(en_v[26]), .out_en27(en_v[27]),
    .out_en28(en_v[28]), .out_en29(en_v[29]), .out_en30(en_v[30]), .out_en31(en_v[31]), .out_en32(en_v[32]), .out_en33(en_v[33]), .out_en34(en_v[34]),
    .out_en35(en_v[35]), .out_en36(en_v[36]), .out_en37(en_v[37]), .out_en38(en_v[38]), .out_en39(en_v[39]), .out_en40(en_v[40]), .out_en41(en_v[41]),
    .out_en42(en_v[42]), .out_en43(en_v[43]), .out_en44(en_v[44]), .out_en45(en_v[45]), .out_en46(en_v[46]), .out_en47(en_v[47]), .out_en48(en_v[48]),
    .out_en49(en_v[49]), .out_en50(en_v[50])
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;                 // edge number since reset release (E1 = 1)
  logic [27:0] exp_q[$];         // expected results, NC entries per frame
  logic [18:0] stim_q[$];        // samples still to be presented
  logic [27:0] last_v [NC];      // last published result per core

  task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int w_ref(input int k, input int i);
    return ((7 * k + 3 * i) % 15) - 7;
  endfunction

  task automatic push_frame(input int s[8]);
    longint acc;
    for (int i = 0; i < 8; i++) stim_q.push_back(s[i][18:0]);
    for (int k = 0; k < NC; k++) begin
      acc = longint'(k);
      for (int i = 0; i < 8; i++) acc += longint'(s[i]) * longint'(w_ref(k, i));
      exp_q.push_back(acc[27:0]);
    end
  endtask

  task automatic wait_pulse(input string tag);
    bit seen;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (en_v[0] == 4'd1) seen = 1;
    end
    chk({tag, "_pulse_seen"}, 28'(seen), 28'd1);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) @(negedge clk);
    chk({tag, "_drain"}, 28'(exp_q.size()), 28'd0);
  endtask

  // ---------------- edge counter ----------------
  initial forever begin
    @(posedge clk);
    cyc = rst ? 0 : cyc + 1;
  end

  // ---------------- source driver ----------------
  // Present the queue head after edges where req was low; once req shows the
  // sample was taken, drop it and put junk on `in` across the wait edge.
  initial begin
    in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (req_v[0] != 4'd1) in = (stim_q.size() > 0) ? stim_q[0] : 19'($urandom);
      @(negedge clk);
      if (!rst && req_v[0] == 4'd1) begin
        if (stim_q.size() > 0) void'(stim_q.pop_front());
        in = 19'($urandom);
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rst) begin
      for (int k = 0; k < NC; k++) last_v[k] = '0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        chk($sformatf("req_in%0d@E%0d", k, cyc), 28'(req_v[k]), (cyc % 2 == 1) ? 28'd1 : 28'd0);
        chk($sformatf("out_en%0d@E%0d", k, cyc), 28'(en_v[k]), (cyc > 0 && cyc % 16 == 0) ? 28'd1 : 28'd0);
      end
      if (cyc > 0 && cyc % 16 == 0) begin
        if (exp_q.size() < NC) begin
          chk("exp_q_depth", 28'(exp_q.size()), 28'(NC));
        end else begin
          for (int k = 0; k < NC; k++) begin
            last_v[k] = exp_q.pop_front();
            chk($sformatf("io_out%0d@E%0d", k, cyc), io_out_v[k], last_v[k]);
          end
        end
      end else begin
        for (int k = 0; k < NC; k++) chk($sformatf("hold_io_out%0d@E%0d", k, cyc), io_out_v[k], last_v[k]);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int s[8];
    rst = 1'b1;

    for (int i = 0; i < 8; i++) s[i] = 1;                       push_frame(s);
    for (int i = 0; i < 8; i++) s[i] = 262143;                  push_frame(s);
    for (int i = 0; i < 8; i++) s[i] = -262144;                 push_frame(s);
    for (int i = 0; i < 8; i++) s[i] = i * 1000 - 3000;         push_frame(s);
    for (int i = 0; i < 8; i++) s[i] = 100000 - i * 30000;      push_frame(s);
    for (int i = 0; i < 8; i++) s[i] = i * i * 3000 - 50000;    push_frame(s);
    for (int i = 0; i < 8; i++) s[i] = int'($urandom_range(0, 524287)) - 262144; push_frame(s);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_io_out0", io_out_v[0], 28'd0);
    chk("rst_req_in0", 28'(req_v[0]), 28'd0);
    chk("rst_out_en0", 28'(en_v[0]), 28'd0);
    #2 rst = 1'b0;

    wait_pulse("ones");
    chk("ones_io_out0", io_out_v[0], -28'sd17);
    chk("ones_io_out1", io_out_v[1], 28'sd10);
    wait_pulse("maxpos");
    chk("maxpos_io_out0", io_out_v[0], -28'sd4456431);
    wait_pulse("maxneg");
    chk("maxneg_io_out0", io_out_v[0], 28'sd4456448);
    drain("stream");

    // Reset in the middle of a frame, just after its third consumed sample.
    for (int t = 0; t < 40 && (cyc % 16) != 5; t++) @(posedge clk);
    chk("midrst_at_E5", 28'(cyc % 16), 28'd5);
    #3 rst = 1'b1;
    #1;
    chk("midrst_io_out0", io_out_v[0], 28'd0);
    chk("midrst_io_out50", io_out_v[50], 28'd0);
    chk("midrst_req_in0", 28'(req_v[0]), 28'd0);
    chk("midrst_out_en0", 28'(en_v[0]), 28'd0);
    stim_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) s[i] = 1;                       push_frame(s);
    for (int i = 0; i < 8; i++) s[i] = int'($urandom_range(0, 524287)) - 262144; push_frame(s);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    wait_pulse("post_rst");
    chk("post_rst_io_out0", io_out_v[0], -28'sd17);
    drain("post_rst");
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
